// File: rtl/piso_serializer_if.sv
// Parallel-word handshake and serial output bundle for the PISO serializer.
// The slave modport is the serializer side; the master modport drives words in.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] par_data_i;
  logic             par_valid_i;
  logic             par_ready_o;
  logic             dir_i;
  logic             data_o;
  logic             data_valid_o;
  logic             busy_o;
  logic             word_done_o;

  modport slave (
    input  par_data_i, par_valid_i, dir_i,
    output par_ready_o, data_o, data_valid_o, busy_o, word_done_o
  );

  modport master (
    output par_data_i, par_valid_i, dir_i,
    input  par_ready_o, data_o, data_valid_o, busy_o, word_done_o
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word over valid/ready
// and emits it one bit per clock, MSB- or LSB-first as chosen at accept time.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  piso_serializer_if.slave     bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic last;
  logic ready;
  logic accept;

  assign last   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  // Ready opens on the last bit as well so back-to-back words leave no bubble.
  assign ready  = !rst_i && ((state_q == IDLE) || last);
  assign accept = bus.par_valid_i && ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = bus.par_data_i;
          dir_d   = bus.dir_i;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          if (accept) begin
            shreg_d = bus.par_data_i;
            dir_d   = bus.dir_i;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.par_ready_o  = ready;
  assign bus.data_o       = (state_q == SHIFT) && (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign bus.data_valid_o = (state_q == SHIFT);
  assign bus.busy_o       = (state_q == SHIFT);
  assign bus.word_done_o  = last;
endmodule
